// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the signals between the fetch/load-store requesters, the single
// RAM port and the arbiter that sits in between.
//
//   Fetch side      : if_req, if_addr -> ; <- if_ack, if_rdata
//   Load/store side : mem_req, mem_we, mem_addr, mem_sel, mem_wdata -> ;
//                     <- mem_ack, mem_rdata
//   RAM side        : <- ram_ce, ram_we, ram_addr, ram_sel, ram_wdata ;
//                     ram_rdata ->
//   Status          : <- who, stall_req, conflict_cnt
//
// Modports:
//   master - the arbiter itself (it masters the RAM port and answers requests)
//   slave  - the surroundings: pipeline requesters plus the RAM
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [SEL_W-1:0]  ram_sel;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              who;
    logic              stall_req;
    logic [31:0]       conflict_cnt;

    modport master (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        input  ram_rdata,
        output if_ack, if_rdata, mem_ack, mem_rdata,
        output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
        output who, stall_req, conflict_cnt
    );

    modport slave (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        output ram_rdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata,
        input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
        input  who, stall_req, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Serializes instruction-fetch and load/store requests onto the single
// unified RAM port. Each access takes an ACCESS cycle (RAM enabled, RAM
// samples at its end) followed by a RESP cycle (ack pulse, read data passed
// straight through from the RAM). During RESP the next requester is chosen
// with the just-served one masked, so continuous contention alternates and
// the port sustains one access every two cycles.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - mem_port_arbiter_if.master: requester handshakes, RAM port,
//          owner (who), stall request and contention counter
//
// Build option:
//   ARB_CONFLICT_CNT_EN - when defined, conflict_cnt counts (saturating)
//   the cycles in which one requester waits while the other owns the port.
//   When undefined, conflict_cnt is tied to zero.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;     // 0 = fetch, 1 = load/store
    logic              store_reg, store_next;     // access in flight is a store
    logic              ram_ce_reg, ram_ce_next;
    logic              ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [SEL_W-1:0]  ram_sel_reg, ram_sel_next;
    logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;

    logic take_mem;
    logic take_if;
    logic if_ack;
    logic mem_ack;

    // Next-state and next RAM-port values. RAM outputs default to zero so
    // they are only non-zero in the cycle that follows a grant (ACCESS).
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        store_next     = store_reg;
        ram_ce_next    = 1'b0;
        ram_we_next    = 1'b0;
        ram_addr_next  = '0;
        ram_sel_next   = '0;
        ram_wdata_next = '0;
        take_mem       = 1'b0;
        take_if        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Load/store wins a tie.
                if (bus.mem_req) begin
                    take_mem = 1'b1;
                end else if (bus.if_req) begin
                    take_if = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                // The requester being acked now is masked: its req this cycle
                // is still the old request, and masking it gives alternation.
                if (!owner_reg && bus.mem_req) begin
                    take_mem = 1'b1;
                end else if (owner_reg && bus.if_req) begin
                    take_if = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (take_mem) begin
            state_next     = ST_ACCESS;
            owner_next     = 1'b1;
            store_next     = bus.mem_we;
            ram_ce_next    = 1'b1;
            ram_we_next    = bus.mem_we;
            ram_addr_next  = bus.mem_addr;
            ram_sel_next   = bus.mem_sel;
            ram_wdata_next = bus.mem_wdata;
        end else if (take_if) begin
            state_next     = ST_ACCESS;
            owner_next     = 1'b0;
            store_next     = 1'b0;
            ram_ce_next    = 1'b1;
            ram_addr_next  = bus.if_addr;
            ram_sel_next   = {SEL_W{1'b1}};
        end
    end

    // Asynchronous reset drops ram_ce/ram_we at once, so a store caught in
    // ACCESS is abandoned unless the RAM edge already happened.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= 1'b0;
            store_reg     <= 1'b0;
            ram_ce_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_sel_reg   <= '0;
            ram_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            store_reg     <= store_next;
            ram_ce_reg    <= ram_ce_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_sel_reg   <= ram_sel_next;
            ram_wdata_reg <= ram_wdata_next;
        end
    end

    assign if_ack  = (state_reg == ST_RESP) && !owner_reg;
    assign mem_ack = (state_reg == ST_RESP) &&  owner_reg;

    assign bus.if_ack    = if_ack;
    assign bus.mem_ack   = mem_ack;
    // Read data is steered from the RAM in the ack cycle only; stores return 0.
    assign bus.if_rdata  = if_ack ? bus.ram_rdata : '0;
    assign bus.mem_rdata = (mem_ack && !store_reg) ? bus.ram_rdata : '0;

    assign bus.ram_ce    = ram_ce_reg;
    assign bus.ram_we    = ram_we_reg;
    assign bus.ram_addr  = ram_addr_reg;
    assign bus.ram_sel   = ram_sel_reg;
    assign bus.ram_wdata = ram_wdata_reg;
    assign bus.who       = owner_reg;
    assign bus.stall_req = (bus.if_req & ~if_ack) | (bus.mem_req & ~mem_ack);

`ifdef ARB_CONFLICT_CNT_EN
    logic [31:0] conflict_cnt_reg;
    logic        other_waiting;

    // The non-owner can never be acked while the port is busy, so its req
    // alone marks a waiting cycle.
    assign other_waiting = (state_reg != ST_IDLE) &&
                           (owner_reg ? (bus.if_req & ~if_ack) : (bus.mem_req & ~mem_ack));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_reg <= '0;
        end else if (other_waiting && (conflict_cnt_reg != 32'hFFFF_FFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
        end
    end

    assign bus.conflict_cnt = conflict_cnt_reg;
`else
    assign bus.conflict_cnt = '0;
`endif

endmodule
